// File: rtl/word_lane_scheduler.sv
// Round-robin scheduler that serializes 32-bit words from two requesters onto one
// 8-bit valid/ready lane, least-significant byte first.
module word_lane_scheduler (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_req0_valid,
    input  logic [31:0] i_req0_word,
    output logic        o_req0_ready,
    input  logic        i_req1_valid,
    input  logic [31:0] i_req1_word,
    output logic        o_req1_ready,
    output logic        o_bus_valid,
    output logic [7:0]  o_bus_data,
    output logic        o_bus_last,
    output logic        o_bus_src,
    input  logic        i_bus_ready,
    output logic        o_busy
);

    typedef enum logic {StIdle, StSend} state_e;

    state_e      r_state, w_state_d;
    logic [31:0] r_shift, w_shift_d;
    logic [1:0]  r_beat, w_beat_d;
    logic        r_src, w_src_d;
    logic        r_last_grant, w_last_grant_d;
    logic        w_idle;
    logic        w_acc0;
    logic        w_acc1;
    logic        w_xfer;

    // Ready is gated by rst_n so neither requester sees an accept while reset is held.
    assign w_idle       = (r_state == StIdle) && rst_n;
    assign o_req0_ready = w_idle && i_req0_valid && (!i_req1_valid || r_last_grant);
    assign o_req1_ready = w_idle && i_req1_valid && (!i_req0_valid || !r_last_grant);
    assign w_acc0       = o_req0_ready && i_req0_valid;
    assign w_acc1       = o_req1_ready && i_req1_valid;

    assign o_bus_valid  = (r_state == StSend);
    assign o_bus_data   = (r_state == StSend) ? r_shift[7:0] : 8'h00;
    assign o_bus_last   = (r_state == StSend) && (r_beat == 2'd3);
    assign o_bus_src    = r_src;
    assign o_busy       = (r_state == StSend);
    assign w_xfer       = o_bus_valid && i_bus_ready;

    always_comb begin
        w_state_d      = r_state;
        w_shift_d      = r_shift;
        w_beat_d       = r_beat;
        w_src_d        = r_src;
        w_last_grant_d = r_last_grant;
        unique case (r_state)
            StIdle: begin
                if (w_acc0 || w_acc1) begin
                    w_shift_d      = w_acc1 ? i_req1_word : i_req0_word;
                    w_src_d        = w_acc1;
                    w_last_grant_d = w_acc1;
                    w_beat_d       = 2'd0;
                    w_state_d      = StSend;
                end
            end
            StSend: begin
                if (w_xfer) begin
                    w_shift_d = {8'h00, r_shift[31:8]};
                    w_beat_d  = r_beat + 2'd1;
                    if (r_beat == 2'd3) begin
                        w_state_d = StIdle;
                    end
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= StIdle;
            r_shift      <= 32'h0;
            r_beat       <= 2'd0;
            r_src        <= 1'b0;
            r_last_grant <= 1'b1;
        end else begin
            r_state      <= w_state_d;
            r_shift      <= w_shift_d;
            r_beat       <= w_beat_d;
            r_src        <= w_src_d;
            r_last_grant <= w_last_grant_d;
        end
    end

endmodule

// File: tb/tb_word_lane_scheduler.sv
// Scoreboard bench: a behavioural arbiter model pushes expected beats at accept and the
// monitor pops and compares them as beats transfer on the lane.
module tb_word_lane_scheduler;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_req0_valid = 1'b0, i_req1_valid = 1'b0;
    logic [31:0] i_req0_word = 32'h0, i_req1_word = 32'h0;
    logic        o_req0_ready, o_req1_ready;
    logic        o_bus_valid, o_bus_last, o_bus_src, o_busy;
    logic [7:0]  o_bus_data;
    logic        i_bus_ready = 1'b1;

    word_lane_scheduler dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_req0_valid (i_req0_valid),
        .i_req0_word  (i_req0_word),
        .o_req0_ready (o_req0_ready),
        .i_req1_valid (i_req1_valid),
        .i_req1_word  (i_req1_word),
        .o_req1_ready (o_req1_ready),
        .o_bus_valid  (o_bus_valid),
        .o_bus_data   (o_bus_data),
        .o_bus_last   (o_bus_last),
        .o_bus_src    (o_bus_src),
        .i_bus_ready  (i_bus_ready),
        .o_busy       (o_busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Model state: {src, last, data} per expected beat.
    logic [9:0] sb[$];
    bit         m_idle = 1'b1;
    bit         m_last = 1'b1;
    int         m_beats = 0;
    int         cyc = 0;
    int         acc_cnt = 0;
    int         prev_acc = -1;
    bit         chk_gap = 1'b0;
    bit         stall_hold = 1'b0;
    logic [9:0] held;

    task automatic push_word(input logic src, input logic [31:0] w);
        for (int b = 0; b < 4; b++) sb.push_back({src, (b == 3), w[8*b +: 8]});
    endtask

    always @(negedge clk) begin
        logic exp_r0, exp_r1;
        logic [9:0] cur, e;
        bit was_idle;
        cyc++;
        if (!rst_n) begin
            sb.delete();
            m_idle = 1'b1; m_last = 1'b1; m_beats = 0; stall_hold = 1'b0;
            check("rst_valid", o_bus_valid, 0);
            check("rst_r0", o_req0_ready, 0);
            check("rst_r1", o_req1_ready, 0);
        end else begin
            was_idle = m_idle;
            exp_r0 = was_idle && i_req0_valid && (!i_req1_valid || m_last);
            exp_r1 = was_idle && i_req1_valid && (!i_req0_valid || !m_last);
            check("r0", o_req0_ready, exp_r0);
            check("r1", o_req1_ready, exp_r1);
            check("busy", o_busy, !was_idle);
            check("bus_valid", o_bus_valid, !was_idle);
            check("ready_overlap", (o_req0_ready | o_req1_ready) & o_bus_valid, 0);
            cur = {o_bus_src, o_bus_last, o_bus_data};
            if (was_idle) begin
                check("idle_data", {o_bus_last, o_bus_data}, 0);
            end else begin
                if (stall_hold) check("stall_stable", cur, held);
                if (i_bus_ready) begin
                    if (sb.size() == 0) begin
                        check("sb_empty", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        check("beat", cur, e);
                    end
                    m_beats--;
                    if (m_beats == 0) m_idle = 1'b1;
                end
                stall_hold = !i_bus_ready;
                held = cur;
            end
            if (exp_r0 || exp_r1) begin
                push_word(exp_r1, exp_r1 ? i_req1_word : i_req0_word);
                m_last = exp_r1; m_idle = 1'b0; m_beats = 4; acc_cnt++;
                if (chk_gap && prev_acc >= 0) check("gap", cyc - prev_acc, 5);
                prev_acc = cyc;
            end
        end
    end

    task automatic send_word(input logic src, input logic [31:0] w);
        bit done = 1'b0;
        if (src) begin i_req1_word = w; i_req1_valid = 1'b1; end
        else     begin i_req0_word = w; i_req0_valid = 1'b1; end
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (src ? o_req1_ready : o_req0_ready) done = 1'b1;
        end
        if (!done) check("send_timeout", 0, 1);
        @(posedge clk); #1;
        if (src) i_req1_valid = 1'b0; else i_req0_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit done = 1'b0;
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge clk);
            if (m_idle && sb.size() == 0) done = 1'b1;
        end
        if (!done) check("idle_timeout", 0, 1);
        @(posedge clk); #1;
    endtask

    task automatic wait_accepts(input int target);
        bit done = 1'b0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (acc_cnt >= target) done = 1'b1;
        end
        if (!done) check("accept_timeout", 0, 1);
        @(posedge clk); #1;
    endtask

    logic pat[7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

    initial begin
        // Reset state with requests asserted: readies must stay low.
        i_req0_valid = 1'b1; i_req1_valid = 1'b1;
        #2;
        check("rst_bus", {o_bus_valid, o_bus_last, o_bus_src, o_busy, o_bus_data}, 0);
        check("rst_rdy", {o_req0_ready, o_req1_ready}, 0);
        repeat (2) @(posedge clk);
        #1 i_req0_valid = 1'b0; i_req1_valid = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;

        // Tie: req0 wins first, then strict alternation, 5 cycles apart.
        i_req0_word = 32'hA0A1A2A3; i_req1_word = 32'hB0B1B2B3;
        chk_gap = 1'b1; prev_acc = -1;
        i_req0_valid = 1'b1; i_req1_valid = 1'b1;
        wait_accepts(acc_cnt + 4);
        i_req0_valid = 1'b0; i_req1_valid = 1'b0;
        wait_idle();
        chk_gap = 1'b0;

        // Single word.
        send_word(1'b0, 32'h11223344);
        wait_idle();

        // Backpressure.
        i_bus_ready = 1'b0;
        send_word(1'b0, 32'hDEADBEEF);
        for (int i = 0; i < 7; i++) begin
            i_bus_ready = pat[i];
            @(posedge clk); #1;
        end
        i_bus_ready = 1'b1;
        wait_idle();

        // Word change after accept must not affect the word in flight.
        send_word(1'b1, 32'h01020304);
        i_req1_word = 32'hFFFFFFFF;
        wait_idle();

        // Reset after the second beat.
        send_word(1'b0, 32'h55667788);
        @(posedge clk); @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("async_drop", {o_bus_valid, o_busy}, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        i_req1_word = 32'h99AABBCC; i_req1_valid = 1'b1;
        @(negedge clk);
        check("post_rst_accept", o_req1_ready, 1);
        @(posedge clk); #1 i_req1_valid = 1'b0;
        wait_idle();

        // Streaming from req1 alone.
        chk_gap = 1'b1; prev_acc = -1;
        i_req1_word = 32'hC3C2C1C0; i_req1_valid = 1'b1;
        wait_accepts(acc_cnt + 3);
        i_req1_valid = 1'b0;
        wait_idle();
        chk_gap = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/word_lane_scheduler.md
# word_lane_scheduler

Shares a single 8-bit byte lane between two 32-bit word requesters. A granted word is serialized onto the lane as four byte beats, least-significant byte first, under a valid/ready handshake. Arbitration between requesters is round-robin. The block sits between 32-bit producers (e.g. PC/address sources) and the 8-bit bus, and performs the sequenced equivalent of splitting a word into bytes out0..out3.

## Interface
- Parameters: none. Word width is fixed at 32, lane width at 8, beats per word at 4.
- clk  in  1  single clock; all state updates on its rising edge
- rst_n  in  1  reset, asynchronous, active-low
- req0_valid  in  1  requester 0 has a word to send
- req0_word  in  32  requester 0 word
- req0_ready  out  1  requester 0 word accepted this cycle (combinational)
- req1_valid  in  1  requester 1 has a word to send
- req1_word  in  32  requester 1 word
- req1_ready  out  1  requester 1 word accepted this cycle (combinational)
- bus_valid  out  1  byte on bus_data is valid
- bus_data  out  8  current byte
- bus_last  out  1  current beat is byte 3 of the word
- bus_src  out  1  index of the requester that owns the word in flight
- bus_ready  in  1  lane consumer accepts the current beat
- busy  out  1  a word is in flight (state SEND)

## Operation
- States:
  - IDLE: no word held.
  - SEND: word held in a 32-bit shift register, beat counter `beat` in the range 0..3.
- Internal `last_grant` (1 bit) holds the requester granted most recently.
- Arbitration happens in IDLE only:
  - If exactly one req valid, that requester is granted.
  - If both are valid, the requester != last_grant is granted.
  - The granted requester's reqN_ready is driven high combinationally in IDLE. The other ready stays 0. Both are 0 in SEND.
- Accept: when valid && ready on the rising edge:
  - shift ← reqN_word
  - bus_src ← N
  - last_grant ← N
  - beat ← 0
  - state ← SEND
- In SEND:
  - bus_valid = 1
  - bus_data = shift[7:0]
  - bus_last = (beat == 3)
- Beat transfer (bus_valid && bus_ready at the edge):
  - shift ← shift >> 8, with zero fill
  - beat ← beat + 1
- When the beat with bus_last = 1 transfers, state ← IDLE.
- Byte order on the lane: word[7:0], word[15:8], word[23:16], word[31:24].
- bus_ready low stalls the lane. bus_data, bus_last and bus_src hold unchanged until the beat transfers.
- A requester's word is sampled only at accept. Later changes to reqN_word do not affect the word in flight.
- In IDLE: bus_valid = 0, bus_last = 0, bus_data = 8'h00. bus_src holds its last value.

## Timing
- Reset (rst_n low, asynchronously): state = IDLE, shift = 0, beat = 0, bus_src = 0, last_grant = 1 (requester 0 wins the first tie).
- Output values during reset:
  - bus_valid = 0, bus_last = 0, bus_data = 0, busy = 0
  - req0_ready = 0 and req1_ready = 0 while rst_n is low
- Reset mid-word: the word in flight is dropped and no further beats are driven. After release, arbitration starts from last_grant = 1.
- Latency:
  - Word accepted at edge N; byte 0 is valid from cycle N+1.
  - With bus_ready held high, byte 3 transfers at edge N+4 and the block is in IDLE at N+4.
  - A new word can be accepted at edge N+5, giving a minimum of 5 cycles per word.
- reqN_ready must not be high in the same cycle as bus_valid.
- A requester that drops valid before being granted simply loses its turn. last_grant does not change.
- A held request from the other requester is granted on the very next IDLE cycle. A word of one requester can never be followed by more than one word of the other while it waits, so there is no starvation.

## Test plan
- Single word: req0 sends 32'h11223344 with bus_ready = 1. Required:
  - req0_ready pulses for 1 cycle.
  - Beats 44, 33, 22, 11 on consecutive cycles, with bus_last only on 11 and bus_src = 0.
  - busy high for exactly 4 cycles.
- Tie and round-robin: after reset, both requesters valid and held, req0 = 32'hA0A1A2A3, req1 = 32'hB0B1B2B3. Required:
  - Word order on the lane is req0, req1, req0, req1.
  - The bus_src sequence is 0, 1, 0, 1.
  - Successive words start 5 cycles apart.
- Backpressure: bus_ready toggles 1,0,0,1,0,1,1 during a word 32'hDEADBEEF. Required:
  - Bytes EF, BE, AD, DE, each held stable while stalled.
  - No byte repeated or skipped.
  - bus_last is high only while DE is presented.
- Input change after accept: req1_word changes from 32'h01020304 to 32'hFFFFFFFF one cycle after accept. Required: the lane still carries 04, 03, 02, 01.
- Reset mid-word: assert rst_n low after the second beat of 32'h55667788. Required:
  - bus_valid falls immediately, asynchronously.
  - No further beats are driven.
  - After release, a new req1-only word is accepted on the first IDLE cycle.
- Single requester streaming: req1 alone and continuously valid. Required: every word is granted to req1 with no idle gap beyond the mandatory 1 IDLE cycle, and req0_ready stays 0.
